// File: rtl/uart_rx_if.sv
// Receive-side bundle: the serial line in, the parallel word and its status strobes out.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  line;
  logic [DATA_WIDTH-1:0] received_data;
  logic                  valid;
  logic                  frame_error;
  logic                  parity_error;
  logic                  busy;

  modport master (
    output line,
    input  received_data, valid, frame_error, parity_error, busy
  );

  modport slave (
    input  line,
    output received_data, valid, frame_error, parity_error, busy
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit validation, centre sampling, frame-error reporting.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data and the stop bit.
module uart_rx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUDRATE   = 9600,
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input logic      clk,
  input logic      reset,
  uart_rx_if.slave bus
);

  localparam int DIV_RAW = CLK_FREQ / (BAUDRATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SMP_W   = $clog2(OVERSAMPLE);
  localparam int IDX_W   = $clog2(DATA_WIDTH + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [SMP_W-1:0] SMP_HALF = SMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_e;
`endif

  state_e                state_q, state_d;
  logic                  sync1_q, sync2_q;
  logic [1:0]            fill_q;
  logic                  armed_q, armed_d;
  logic [DIV_W-1:0]      divCnt_q, divCnt_d;
  logic [SMP_W-1:0]      smpCnt_q, smpCnt_d;
  logic [IDX_W-1:0]      bitIdx_q, bitIdx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  frameErr_q, frameErr_d;
  logic                  rx, tick, startDet, halfDone, bitDone;
`ifdef UART_RX_PARITY_EN
  logic                  parBad_q, parBad_d;
  logic                  parityErr_q, parityErr_d;
`endif

  // fill_q marks when sync2_q holds a real line sample rather than its reset value,
  // so a line held low through reset cannot look like an idle-high line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      fill_q      <= '0;
      armed_q     <= 1'b0;
      divCnt_q    <= '0;
      state_q     <= IDLE;
      smpCnt_q    <= '0;
      bitIdx_q    <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frameErr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parBad_q    <= 1'b0;
      parityErr_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= bus.line;
      sync2_q     <= sync1_q;
      fill_q      <= {fill_q[0], 1'b1};
      armed_q     <= armed_d;
      divCnt_q    <= divCnt_d;
      state_q     <= state_d;
      smpCnt_q    <= smpCnt_d;
      bitIdx_q    <= bitIdx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frameErr_q  <= frameErr_d;
`ifdef UART_RX_PARITY_EN
      parBad_q    <= parBad_d;
      parityErr_q <= parityErr_d;
`endif
    end
  end

  always_comb begin
    rx         = sync2_q;
    tick       = (divCnt_q == DIV_LAST);
    startDet   = (state_q == IDLE) && armed_q && !rx;
    halfDone   = tick && (smpCnt_q == SMP_HALF);
    bitDone    = tick && (smpCnt_q == SMP_LAST);
    armed_d    = armed_q | (fill_q[1] & rx);
    divCnt_d   = (startDet || tick) ? '0 : divCnt_q + DIV_W'(1);
    state_d    = state_q;
    smpCnt_d   = tick ? smpCnt_q + SMP_W'(1) : smpCnt_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    frameErr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parBad_d    = parBad_q;
    parityErr_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        smpCnt_d = '0;
        if (startDet) state_d = START;
      end
      START: begin
        if (halfDone) begin
          smpCnt_d = '0;
          bitIdx_d = '0;
          state_d  = rx ? IDLE : DATA;
        end
      end
      // Bits arrive LSB first, so shifting in from the top leaves bit 0 at the bottom.
      DATA: begin
        if (bitDone) begin
          smpCnt_d = '0;
          shift_d  = {rx, shift_q[DATA_WIDTH-1:1]};
          bitIdx_d = bitIdx_q + IDX_W'(1);
          if (bitIdx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bitDone) begin
          smpCnt_d = '0;
          parBad_d = rx ^ (^shift_q);
          state_d  = STOP;
        end
      end
`endif
      STOP: begin
        if (bitDone) begin
          smpCnt_d = '0;
          if (rx) begin
            data_d  = shift_q;
            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            parityErr_d = parBad_q;
`endif
            state_d = IDLE;
          end else begin
            frameErr_d = 1'b1;
            state_d    = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.received_data = data_q;
  assign bus.valid         = valid_q;
  assign bus.frame_error   = frameErr_q;
  assign bus.busy          = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_error  = parityErr_q;
`else
  assign bus.parity_error  = 1'b0;
`endif

endmodule
